// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Collects results from N_SRC functional units into small per-source FIFOs
//   and broadcasts one result per cycle on the common data bus (CDB) using a
//   round-robin grant. Once a grant is presented and the CDB stalls, the
//   grant is locked so the broadcast payload stays stable until it is taken.
//
// Handshake: on both sides a transfer happens at a rising edge where
//   valid=1 and ready=1. A valid, once raised on the CDB, keeps its payload
//   unchanged until the transfer. src_ready depends on registered state only.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   flush      : synchronous clear of all buffered results (keeps rr_ptr)
//   src_valid  : per-source result valid                       [N_SRC]
//   src_ready  : per-source accept (FIFO not full)              [N_SRC]
//   src_addr   : per-source dest preg, source i at [i*PREG_W +: PREG_W]
//   src_val    : per-source value,     source i at [i*VAL_W  +: VAL_W]
//   cdb_valid  : CDB broadcast valid
//   cdb_ready  : CDB accept (AND of all consumers)
//   cdb_addr   : broadcast physical register address (0 when idle)
//   cdb_val    : broadcast value (0 when idle)
//   cdb_src    : index of the source driving the CDB (0 when idle)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int N_SRC  = 3,
    parameter int PREG_W = 7,
    parameter int VAL_W  = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_SRC-1:0]           src_valid,
    output logic [N_SRC-1:0]           src_ready,
    input  logic [N_SRC*PREG_W-1:0]    src_addr,
    input  logic [N_SRC*VAL_W-1:0]     src_val,
    output logic                       cdb_valid,
    input  logic                       cdb_ready,
    output logic [PREG_W-1:0]          cdb_addr,
    output logic [VAL_W-1:0]           cdb_val,
    output logic [$clog2(N_SRC)-1:0]   cdb_src
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = $clog2(N_SRC);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRC - 1);

    // FIFO storage and bookkeeping
    logic [PREG_W-1:0] addr_mem_q [N_SRC][DEPTH];
    logic [VAL_W-1:0]  val_mem_q  [N_SRC][DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [N_SRC];
    logic [PTR_W-1:0]  rd_ptr_d [N_SRC];
    logic [PTR_W-1:0]  wr_ptr_q [N_SRC];
    logic [PTR_W-1:0]  wr_ptr_d [N_SRC];
    logic [CNT_W-1:0]  cnt_q    [N_SRC];
    logic [CNT_W-1:0]  cnt_d    [N_SRC];

    // Arbitration state
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [SRC_W-1:0]  lock_idx_q, lock_idx_d;

    logic [N_SRC-1:0]  nonempty;
    logic [N_SRC-1:0]  push;
    logic [N_SRC-1:0]  pop;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  idx;
    logic              found;
    logic              xfer;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            nonempty[i]  = (cnt_q[i] != '0);
            src_ready[i] = !rst && (cnt_q[i] != FULL_CNT);
            push[i]      = src_valid[i] && src_ready[i];
        end
    end

    // Round-robin search from rr_ptr; a registered lock overrides it so the
    // payload cannot change while the CDB is stalled.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            for (int k = 0; k < N_SRC; k++) begin
                idx = SRC_W'((int'(rr_ptr_q) + k) % N_SRC);
                if (!found && nonempty[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign cdb_valid = !rst && (|nonempty);
    assign xfer      = cdb_valid && cdb_ready;
    assign cdb_addr  = cdb_valid ? addr_mem_q[grant][rd_ptr_q[grant]] : '0;
    assign cdb_val   = cdb_valid ? val_mem_q[grant][rd_ptr_q[grant]]  : '0;
    assign cdb_src   = cdb_valid ? grant : '0;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            pop[i]      = xfer && (grant == SRC_W'(i));
            rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (pop[i] && !push[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (xfer) begin
            lock_d   = 1'b0;
            rr_ptr_d = (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);
        end else if (cdb_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (flush) begin
            // Flush drops everything buffered but keeps fairness position.
            for (int i = 0; i < N_SRC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Storage needs no reset; occupancy counters decide what is visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (!rst && !flush && push[i]) begin
                addr_mem_q[i][wr_ptr_q[i]] <= src_addr[i*PREG_W +: PREG_W];
                val_mem_q[i][wr_ptr_q[i]]  <= src_val[i*VAL_W +: VAL_W];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [20:0] src_addr;
    logic [95:0] src_val;
    logic        cdb_valid;
    logic        cdb_ready;
    logic [6:0]  cdb_addr;
    logic [31:0] cdb_val;
    logic [1:0]  cdb_src;
    logic [41:0] cdb_bus;
    logic [41:0] exp_bus;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.N_SRC(3), .PREG_W(7), .VAL_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_addr  (src_addr),
        .src_val   (src_val),
        .cdb_valid (cdb_valid),
        .cdb_ready (cdb_ready),
        .cdb_addr  (cdb_addr),
        .cdb_val   (cdb_val),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    assign cdb_bus = {cdb_valid, cdb_src, cdb_addr, cdb_val};

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [6:0] a, input logic [31:0] v);
        src_valid[s]       = 1'b1;
        src_addr[s*7 +: 7] = a;
        src_val[s*32 +: 32] = v;
    endtask

    function automatic logic [41:0] bus(input logic [1:0] s, input logic [6:0] a,
                                        input logic [31:0] v);
        return {1'b1, s, a, v};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; src_valid = '0; src_addr = '0; src_val = '0;
        cdb_ready = 1'b1;
        tick(); tick();
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL reset_cdb: got %h want %h", cdb_bus, 42'd0);
        end
        checks++;
        if (src_ready !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b want %b", src_ready, 3'b000);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (src_ready !== 3'b111) begin
            errors++; $display("FAIL ready_after_reset: got %b want %b", src_ready, 3'b111);
        end
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL idle_after_reset: got %h want %h", cdb_bus, 42'd0);
        end
        tick();
    endtask

    task automatic test_round_robin();
        drive(0, 7'd1, 32'h101); drive(1, 7'd2, 32'h202); drive(2, 7'd3, 32'h303);
        tick(); src_valid = '0;
        exp_bus = bus(2'd0, 7'd1, 32'h101); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL rr_first: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        exp_bus = bus(2'd1, 7'd2, 32'h202); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL rr_second: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        exp_bus = bus(2'd2, 7'd3, 32'h303); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL rr_third: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL rr_idle: got %h want %h", cdb_bus, 42'd0);
        end
        // rr_ptr must be back at 0: with src0 and src2 pending, src0 wins.
        drive(2, 7'd14, 32'h1414); drive(0, 7'd13, 32'h1313);
        tick(); src_valid = '0;
        exp_bus = bus(2'd0, 7'd13, 32'h1313); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL rr_wrapped_to_0: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        exp_bus = bus(2'd2, 7'd14, 32'h1414); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL rr_then_src2: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
    endtask

    task automatic test_single();
        drive(0, 7'd5, 32'hDEADBEEF);
        tick(); src_valid = '0;
        exp_bus = bus(2'd0, 7'd5, 32'hDEADBEEF); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL single_bcast: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL single_idle: got %h want %h", cdb_bus, 42'd0);
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr=1 here; src1 also pushes so an unlocked grant would move off src2.
        cdb_ready = 1'b0;
        drive(2, 7'd9, 32'h99);
        tick(); src_valid = '0;
        exp_bus = bus(2'd2, 7'd9, 32'h99);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cdb_bus !== exp_bus) begin
                errors++; $display("FAIL bp_hold cycle %0d: got %h want %h", k, cdb_bus, exp_bus);
            end
            if (k == 0) begin
                drive(0, 7'd4, 32'h44); drive(1, 7'd7, 32'h77);
            end
            tick(); src_valid = '0;
        end
        cdb_ready = 1'b1;
        checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL bp_release: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        exp_bus = bus(2'd0, 7'd4, 32'h44); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL bp_src0_next: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        exp_bus = bus(2'd1, 7'd7, 32'h77); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL bp_src1_next: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL bp_idle: got %h want %h", cdb_bus, 42'd0);
        end
    endtask

    task automatic test_full();
        cdb_ready = 1'b0;
        drive(1, 7'd11, 32'hB1);
        tick();
        checks++;
        if (src_ready !== 3'b111) begin
            errors++; $display("FAIL full_one_entry: got %b want %b", src_ready, 3'b111);
        end
        drive(1, 7'd12, 32'hB2);
        tick();
        checks++;
        if (src_ready !== 3'b101) begin
            errors++; $display("FAIL full_two_entries: got %b want %b", src_ready, 3'b101);
        end
        drive(1, 7'd13, 32'hB3);
        tick();
        checks++;
        if (src_ready !== 3'b101) begin
            errors++; $display("FAIL full_third_held: got %b want %b", src_ready, 3'b101);
        end
        exp_bus = bus(2'd1, 7'd11, 32'hB1); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL full_head: got %h want %h", cdb_bus, exp_bus);
        end
        // Pop while full with src_valid still high: no push may slip in.
        cdb_ready = 1'b1;
        tick();
        exp_bus = bus(2'd1, 7'd12, 32'hB2); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL full_drain_second: got %h want %h", cdb_bus, exp_bus);
        end
        checks++;
        if (src_ready !== 3'b111) begin
            errors++; $display("FAIL full_ready_after_pop: got %b want %b", src_ready, 3'b111);
        end
        src_valid = '0;
        tick();
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL full_no_third: got %h want %h", cdb_bus, 42'd0);
        end
    endtask

    task automatic test_flush();
        // rr_ptr=2 entering this test.
        cdb_ready = 1'b0;
        drive(0, 7'd20, 32'hC0); drive(1, 7'd21, 32'hC1);
        tick();
        src_valid[1] = 1'b0; drive(0, 7'd22, 32'hC2);
        tick(); src_valid = '0;
        checks++;
        if (src_ready !== 3'b110) begin
            errors++; $display("FAIL flush_pre_ready: got %b want %b", src_ready, 3'b110);
        end
        exp_bus = bus(2'd0, 7'd20, 32'hC0); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL flush_pre_head: got %h want %h", cdb_bus, exp_bus);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL flush_cycle_outputs: got %h want %h", cdb_bus, exp_bus);
        end
        tick(); flush = 1'b0;
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL flush_empty: got %h want %h", cdb_bus, 42'd0);
        end
        checks++;
        if (src_ready !== 3'b111) begin
            errors++; $display("FAIL flush_ready: got %b want %b", src_ready, 3'b111);
        end
        cdb_ready = 1'b1;
        tick();
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL flush_no_stale: got %h want %h", cdb_bus, 42'd0);
        end
        // rr_ptr kept at 2 and lock cleared: src2 wins over src0.
        drive(0, 7'd23, 32'hD0); drive(2, 7'd24, 32'hD2);
        tick(); src_valid = '0;
        exp_bus = bus(2'd2, 7'd24, 32'hD2); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL flush_rr_kept: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        exp_bus = bus(2'd0, 7'd23, 32'hD0); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL flush_then_src0: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        // rr_ptr=1 entering this test.
        cdb_ready = 1'b0;
        drive(1, 7'd30, 32'hE1);
        tick(); src_valid = '0;
        tick();
        exp_bus = bus(2'd1, 7'd30, 32'hE1); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL lock_src1: got %h want %h", cdb_bus, exp_bus);
        end
        rst = 1'b1; cdb_ready = 1'b1;
        #1;
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL rst_no_transfer: got %h want %h", cdb_bus, 42'd0);
        end
        checks++;
        if (src_ready !== 3'b000) begin
            errors++; $display("FAIL rst_ready_low: got %b want %b", src_ready, 3'b000);
        end
        tick(); rst = 1'b0;
        #1;
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL rst_discarded: got %h want %h", cdb_bus, 42'd0);
        end
        checks++;
        if (src_ready !== 3'b111) begin
            errors++; $display("FAIL rst_ready_high: got %b want %b", src_ready, 3'b111);
        end
        // rr_ptr reset to 0: src0 beats src1.
        drive(0, 7'd31, 32'hF0); drive(1, 7'd32, 32'hF1);
        tick(); src_valid = '0;
        exp_bus = bus(2'd0, 7'd31, 32'hF0); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL rst_rr_zero: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        exp_bus = bus(2'd1, 7'd32, 32'hF1); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL rst_then_src1: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        drive(2, 7'd33, 32'hF2);
        tick(); src_valid = '0;
        exp_bus = bus(2'd2, 7'd33, 32'hF2); checks++;
        if (cdb_bus !== exp_bus) begin
            errors++; $display("FAIL rst_new_src2: got %h want %h", cdb_bus, exp_bus);
        end
        tick();
        checks++;
        if (cdb_bus !== 42'd0) begin
            errors++; $display("FAIL rst_final_idle: got %h want %h", cdb_bus, 42'd0);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_full();
        test_flush();
        test_reset_mid_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
